// File: rtl/tqvp_raster_sequencer.sv
// Beam-synchronised register-write sequencer: replays "at scanline >= Y write V to reg A"
// commands into the VGA register port during horizontal blanking.
// Latency: compare true in WAIT at edge N -> wr_valid during cycle N+1. Backpressure: holds
// wr_valid with stable addr/data until wr_ready; abandons the write (sets late) if blank ends.
//
// Ports: clk/rst (sync, active high); enable; load_en/load_idx/load_data command-table write;
// frame_start/blank/vga_y beam timing; clear_late; wr_valid/wr_ready/wr_addr/wr_data register
// write port; ptr/state/late status.
module tqvp_raster_sequencer #(
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          load_en,
    input  logic [PW-1:0] load_idx,
    input  logic [31:0]   load_data,
    input  logic          frame_start,
    input  logic          blank,
    input  logic [9:0]    vga_y,
    input  logic          clear_late,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [5:0]    wr_addr,
    output logic [8:0]    wr_data,
    output logic [PW-1:0] ptr,
    output logic [1:0]    state,
    output logic          late
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       end_m;
        logic [8:0] val;
        logic [5:0] addr;
        logic [9:0] y;
    } entry_t;

    entry_t          entries_q [DEPTH];
    entry_t          entries_d [DEPTH];
    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [5:0]      wr_addr_q, wr_addr_d;
    logic [8:0]      wr_data_q, wr_data_d;
    logic            late_q, late_d;
    logic            late_set;
    entry_t          cur;

    // Bits [30:25] of a load word carry no meaning.
    logic unused_load_bits;
    assign unused_load_bits = ^load_data[30:25];

    assign cur = entries_q[ptr_q];

    always_comb begin
        entries_d = entries_q;
        if (load_en) begin
            entries_d[load_idx] = entry_t'{load_data[31], load_data[24:16],
                                           load_data[15:10], load_data[9:0]};
        end

        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        late_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_WAIT;
                ptr_d   = '0;
            end
            ST_WAIT: begin
                if (cur.end_m) begin
                    state_d = ST_DONE;
                end else if (blank && (vga_y >= cur.y)) begin
                    // Latched from the stored entry, so a same-cycle load to ptr
                    // cannot alter the write being launched.
                    wr_addr_d = cur.addr;
                    wr_data_d = cur.val;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wr_ready) begin
                    if (ptr_q == PW'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d   = ptr_q + PW'(1);
                        state_d = ST_WAIT;
                    end
                end else if (!blank) begin
                    // Retry the same entry next blank; its Y condition still holds.
                    late_set = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            default: ;
        endcase

        // A write accepted this cycle has already advanced ptr above; the
        // frame restart simply takes precedence for the next state.
        if (frame_start && (state_q != ST_IDLE)) begin
            state_d = ST_WAIT;
            ptr_d   = '0;
        end

        // wr_valid is gated by enable, so no request is outstanding when disabled.
        if (!enable) begin
            state_d  = ST_IDLE;
            ptr_d    = '0;
            late_set = 1'b0;
        end

        late_d = late_set ? 1'b1 : (clear_late ? 1'b0 : late_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entry_t'{1'b1, 9'd0, 6'd0, 10'd0};
            end
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            late_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            late_q    <= late_d;
        end
    end

    assign wr_valid = (state_q == ST_ISSUE) && enable;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign ptr      = ptr_q;
    assign state    = state_q;
    assign late     = late_q;

endmodule
